// File: rtl/lfsr_pkg.sv
// Shared types, default tap masks and parameter sanity check for the LFSR generator.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  localparam logic [3:0] LFSR_TAPS4_FIB = 4'b1100;
  localparam logic [3:0] LFSR_TAPS4_GAL = 4'b0011;
  localparam logic [7:0] LFSR_TAPS8     = 8'hB8;

  // Galois bit0 is not checked here because the form is chosen at run time.
  function automatic bit check_taps(input int unsigned width,
                                    input logic [31:0] taps,
                                    input logic [31:0] seed);
    if (width < 2 || width > 32) return 1'b0;
    if (taps == '0 || seed == '0) return 1'b0;
    if (width < 32) begin
      if ((taps >> width) != '0) return 1'b0;
      if ((seed >> width) != '0) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state of the LFSR for Fibonacci and Galois forms.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic [WIDTH-1:0] state_i,
  input  lfsr_mode_e       mode_i,
  output logic [WIDTH-1:0] next_o
);

  always_comb begin
    if (mode_i == LFSR_FIB) begin
      next_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
    end else begin
      next_o = {state_i[WIDTH-2:0], 1'b0} ^ (state_i[WIDTH-1] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with run-time Fibonacci/Galois selection, load, lock-up
// recovery and period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] lfsr_o,
  output logic             bit_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o,
  output logic             period_vld_o,
  output logic             lockup_o
);

  if (!check_taps(WIDTH, 32'(TAPS), 32'(SEED))) begin : g_bad_params
    $error("lfsr_gen: illegal WIDTH/TAPS/SEED combination");
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  lfsr_mode_e       mode_q, mode_d;
  logic             vld_q, vld_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  lfsr_mode_e       mode_new;
  logic [WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0] base_start;
  logic [WIDTH-1:0] base_cnt;

  assign mode_new = lfsr_mode_e'(mode_i);

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .state_i (state_q),
    .mode_i  (mode_new),
    .next_o  (step_nxt)
  );

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    vld_d      = vld_q;
    mode_d     = mode_new;
    wrap_d     = 1'b0;
    lockup_d   = 1'b0;
    base_start = start_q;
    base_cnt   = cnt_q;

    if (load_i) begin
      cnt_d = '0;
      if (seed_i != '0) begin
        state_d = seed_i;
        start_d = seed_i;
      end else begin
        state_d  = SEED;
        start_d  = SEED;
        lockup_d = 1'b1;
      end
    end else if (state_q == '0) begin
      state_d  = SEED;
      start_d  = SEED;
      cnt_d    = '0;
      lockup_d = 1'b1;
    end else begin
      // A mode change rebases the measurement before a same-cycle step is judged.
      if (mode_new != mode_q) begin
        base_start = state_q;
        base_cnt   = '0;
        start_d    = state_q;
        cnt_d      = '0;
      end
      if (en_i) begin
        state_d = step_nxt;
        if (step_nxt == base_start) begin
          wrap_d   = 1'b1;
          period_d = base_cnt + ONE;
          vld_d    = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = base_cnt + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEED;
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      mode_q   <= LFSR_FIB;
      vld_q    <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      vld_q    <= vld_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign lfsr_o       = state_q;
  assign bit_o        = state_q[WIDTH-1];
  assign wrap_o       = wrap_q;
  assign period_o     = period_q;
  assign period_vld_o = vld_q;
  assign lockup_o     = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench: two 4-bit generators with different taps/seeds share stimulus
// and are compared every cycle against an arithmetic model, plus directed sequences.
module tb_lfsr_gen;

  localparam logic [3:0] F_TAPS = 4'b1010;
  localparam logic [3:0] F_SEED = 4'b0010;
  localparam logic [3:0] G_TAPS = 4'b0011;
  localparam logic [3:0] G_SEED = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, ld = 1'b0, md = 1'b0;
  logic [3:0] sd = '0;

  logic [3:0] f_lfsr, f_per, g_lfsr, g_per;
  logic       f_bit, f_wrap, f_vld, f_lock;
  logic       g_bit, g_wrap, g_vld, g_lock;

  int total = 0;
  int bad = 0;

  typedef struct {
    int st; int start; int cnt; int mode; int period; int vld; int wrap; int lock;
  } mdl_t;

  mdl_t mf, mg;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .TAPS(F_TAPS), .SEED(F_SEED)) dut_f (
    .clk(clk), .reset(reset), .en_i(en), .load_i(ld), .seed_i(sd), .mode_i(md),
    .lfsr_o(f_lfsr), .bit_o(f_bit), .wrap_o(f_wrap), .period_o(f_per),
    .period_vld_o(f_vld), .lockup_o(f_lock)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(G_TAPS), .SEED(G_SEED)) dut_g (
    .clk(clk), .reset(reset), .en_i(en), .load_i(ld), .seed_i(sd), .mode_i(md),
    .lfsr_o(g_lfsr), .bit_o(g_bit), .wrap_o(g_wrap), .period_o(g_per),
    .period_vld_o(g_vld), .lockup_o(g_lock)
  );

  function automatic int nextval(input int s, input int mode, input int taps);
    int v;
    v = (s * 2) % 16;
    if (mode == 0) return v + ($countones(s & taps) % 2);
    return (s >= 8) ? (v ^ taps) : v;
  endfunction

  function automatic mdl_t reset_m(input int seed);
    mdl_t r;
    r.st = seed; r.start = seed; r.cnt = 0; r.mode = 0;
    r.period = 0; r.vld = 0; r.wrap = 0; r.lock = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int taps, input int seed,
                                 input int e, input int l, input int s, input int mode);
    mdl_t r;
    int nx;
    r = m; r.wrap = 0; r.lock = 0; r.mode = mode;
    if (l != 0) begin
      r.cnt = 0;
      if (s != 0) begin r.st = s; r.start = s; end
      else begin r.st = seed; r.start = seed; r.lock = 1; end
    end else if (m.st == 0) begin
      r.st = seed; r.start = seed; r.cnt = 0; r.lock = 1;
    end else begin
      if (mode != m.mode) begin r.start = m.st; r.cnt = 0; end
      if (e != 0) begin
        nx = nextval(m.st, mode, taps);
        r.st = nx;
        if (nx == r.start) begin
          r.wrap = 1; r.period = (r.cnt + 1) % 16; r.vld = 1; r.cnt = 0;
        end else begin
          r.cnt = (r.cnt + 1) % 16;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("f.lfsr",   32'(f_lfsr), 32'(mf.st));
    chk("f.bit",    32'(f_bit),  32'((mf.st >> 3) & 1));
    chk("f.wrap",   32'(f_wrap), 32'(mf.wrap));
    chk("f.period", 32'(f_per),  32'(mf.period));
    chk("f.vld",    32'(f_vld),  32'(mf.vld));
    chk("f.lockup", 32'(f_lock), 32'(mf.lock));
    chk("g.lfsr",   32'(g_lfsr), 32'(mg.st));
    chk("g.bit",    32'(g_bit),  32'((mg.st >> 3) & 1));
    chk("g.wrap",   32'(g_wrap), 32'(mg.wrap));
    chk("g.period", 32'(g_per),  32'(mg.period));
    chk("g.vld",    32'(g_vld),  32'(mg.vld));
    chk("g.lockup", 32'(g_lock), 32'(mg.lock));
  endtask

  task automatic cyc(input logic e, input logic l, input logic [3:0] s, input logic m);
    en = e; ld = l; sd = s; md = m;
    @(posedge clk);
    mf = mstep(mf, int'(F_TAPS), int'(F_SEED), int'(e), int'(l), int'(s), int'(m));
    mg = mstep(mg, int'(G_TAPS), int'(G_SEED), int'(e), int'(l), int'(s), int'(m));
    #1;
    check_all();
  endtask

  initial begin
    int fib_exp[6] = '{5, 10, 4, 8, 1, 2};
    int sw_exp[7]  = '{14, 6, 12, 2, 4, 8, 10};
    int gal_exp[7] = '{2, 4, 8, 3, 6, 12, 11};
    logic [3:0] held;
    logic       cur_m;

    held = '0;
    cur_m = 1'b0;
    mf = reset_m(int'(F_SEED));
    mg = reset_m(int'(G_SEED));
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 4'h0, 1'b0);
      chk("fib_seq", 32'(f_lfsr), 32'(fib_exp[i]));
    end
    chk("fib_wrap", 32'(f_wrap), 32'd1);
    chk("fib_period", 32'(f_per), 32'd6);
    chk("fib_vld", 32'(f_vld), 32'd1);

    for (int i = 0; i < 12; i++) begin
      cyc(((i % 4) == 0) || ((i % 4) == 3), 1'b0, 4'h0, 1'b0);
      if ((i % 4) == 0) held = f_lfsr;
      if ((i % 4) == 2) chk("gap_hold", 32'(f_lfsr), 32'(held));
    end
    chk("gap_wrap", 32'(f_wrap), 32'd1);
    chk("gap_period", 32'(f_per), 32'd6);

    cyc(1'b1, 1'b1, 4'h9, 1'b0);
    chk("load_nostep_f", 32'(f_lfsr), 32'h9);
    chk("load_nostep_g", 32'(g_lfsr), 32'h9);
    cyc(1'b0, 1'b1, 4'h0, 1'b0);
    chk("load0_seed", 32'(f_lfsr), 32'(F_SEED));
    chk("load0_lock", 32'(f_lock), 32'd1);
    chk("load_keep_period", 32'(f_per), 32'd6);
    chk("load_keep_vld", 32'(f_vld), 32'd1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    chk("lock_once", 32'(f_lock), 32'd0);

    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    chk("pre_switch", 32'(f_lfsr), 32'hA);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
      chk("sw_seq", 32'(f_lfsr), 32'(sw_exp[i]));
      chk("sw_wrap", 32'(f_wrap), 32'(i == 6));
    end
    chk("sw_period", 32'(f_per), 32'd7);

    cyc(1'b0, 1'b1, 4'h1, 1'b1);
    chk("gal_load", 32'(g_lfsr), 32'h1);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, 4'h0, 1'b1);
      if (i < 7) chk("gal_seq", 32'(g_lfsr), 32'(gal_exp[i]));
      chk("gal_wrap", 32'(g_wrap), 32'(i == 14));
    end
    chk("gal_period", 32'(g_per), 32'd15);

    cur_m = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic e, l;
      logic [3:0] s;
      e = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 19) == 0);
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) cur_m = ~cur_m;
      cyc(e, l, s, cur_m);
    end

    cyc(1'b1, 1'b0, 4'h0, cur_m);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_f_lfsr", 32'(f_lfsr), 32'(F_SEED));
    chk("arst_g_lfsr", 32'(g_lfsr), 32'(G_SEED));
    chk("arst_f_vld", 32'(f_vld), 32'd0);
    chk("arst_g_vld", 32'(g_vld), 32'd0);
    chk("arst_f_period", 32'(f_per), 32'd0);
    chk("arst_pulses", 32'({f_wrap, f_lock, g_wrap, g_lock}), 32'd0);
    mf = reset_m(int'(F_SEED));
    mg = reset_m(int'(G_SEED));
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    chk("post_arst_step", 32'(f_lfsr), 32'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised successor to the team's fixed 4-bit LFSR. Width, feedback taps and seed are parameters.
- Fibonacci or Galois form is selected at run time. Adds enable/load control, all-zero lock-up recovery, and a hardware period-measurement counter.
- Serves as the PRBS/scrambler source for downstream test and stimulus blocks.

Parameters:
- WIDTH, 8, register width; legal range 2..32.
- TAPS, 8'hB8, feedback mask of WIDTH bits. Fibonacci uses the set bits as XOR inputs. Galois uses the mask as the toggle pattern, and bit0 must be 1.
- SEED, 8'h01, reset and recovery value of WIDTH bits; must be nonzero.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to clk externally.
- en_i  in  1  advance the LFSR one step this cycle.
- load_i  in  1  load seed_i this cycle; overrides en_i.
- seed_i  in  WIDTH  load value.
- mode_i  in  1  0 = Fibonacci, 1 = Galois; sampled every cycle.
- lfsr_o  out  WIDTH  current registered state.
- bit_o  out  1  serial output, always equal to lfsr_o[WIDTH-1].
- wrap_o  out  1  one-cycle pulse when a step returns the state to the start value.
- period_o  out  WIDTH  last measured period in steps.
- period_vld_o  out  1  high once the first period has been measured.
- lockup_o  out  1  one-cycle pulse on all-zero recovery.

Behaviour:
- Reset (reset=0):
  - state=SEED, start=SEED, cnt=0, mode_q=0.
  - period_o=0, period_vld_o=0, wrap_o=0, lockup_o=0.
- Next-state function (s = state):
  - Fibonacci: next = {s[WIDTH-2:0], ^(s & TAPS)}.
  - Galois: next = {s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? TAPS : 0).
- Outputs are registered; lfsr_o shows the post-step state one cycle after en_i.
- Priority each cycle: load_i > mode change > en_i > hold.
- Load:
  - seed_i != 0: state=seed_i, start=seed_i, cnt=0.
  - seed_i == 0: state=SEED, start=SEED, cnt=0, and lockup_o pulses the following cycle.
  - period_o and period_vld_o are retained across a load.
- Mode change (mode_i != mode_q, no load):
  - mode_q updates; start=current state, cnt=0.
  - If en_i is also high, the step is taken in the new mode.
- Step (en_i=1, no load):
  - state=next, cnt=cnt+1.
  - If next==start: wrap_o=1, period_o=cnt+1, period_vld_o=1, cnt=0.
- Counter width:
  - cnt is WIDTH bits; a maximal period of 2^WIDTH-1 fits.
  - For a non-maximal sequence that never returns to start, cnt wraps modulo 2^WIDTH silently and no wrap_o is generated.
- All-zero safety:
  - If state is ever 0, the next cycle forces state=SEED, start=SEED, cnt=0, lockup_o=1, whatever en_i is.
  - Load still has priority.
- en_i=0: state, cnt and start hold; wrap_o=0.
- Reset mid-sequence: immediate return to the reset values above; no pulses are generated.

Decomposition:
- Package lfsr_pkg:
  - mode enum lfsr_mode_e {LFSR_FIB=1'b0, LFSR_GAL=1'b1}.
  - Default taps constants (4-bit 4'b1100 Fibonacci, 4'b0011 Galois, 8-bit 8'hB8).
  - Function check_taps, used by an elaboration assertion.
- Sub-module lfsr_next: purely combinational next-state for both modes, parametrised by WIDTH/TAPS.
- lfsr_gen owns the registers, priority logic, period counter and lock-up detection.

Test Plan:
- WIDTH=4, TAPS=4'b1010, SEED=4'b0010, Fibonacci, en_i=1 -> lfsr_o 0101,1010,0100,1000,0001,0010. wrap_o pulses on the 6th step; period_o=6, period_vld_o=1.
- WIDTH=4, TAPS=4'b0011, Galois, load 4'b0001 -> 0010,0100,1000,0011,0110,1100,1011,... period_o=15 after 15 steps.
- load_i=1 with seed_i=0 -> lfsr_o=SEED next cycle and lockup_o pulses once. load_i=1, en_i=1 with seed_i=4'h9 -> lfsr_o=9, no step taken.
- Toggle en_i 1,0,0,1 -> state and cnt frozen while low. Period still measured correctly (6 in the first scenario) with enable gaps inserted.
- Switch mode_i from Fibonacci to Galois at state 4'b1010 -> cnt restarts and start=1010. wrap_o fires only when 1010 recurs under Galois.
- Assert reset mid-sequence (async, between edges) -> lfsr_o=SEED immediately, period_vld_o=0, all pulses low.
